// File: rtl/pwm_envelope.sv
// pwm_envelope: ADSR-style amplitude envelope that scales a PWM compare stream.
// A free-running tick divider paces the envelope; gate edges steer the state
// machine and the current level multiplies the incoming compare sample.
module pwm_envelope #(
    parameter int TICK_DIV      = 48000,
    parameter int ATTACK_STEP   = 8,
    parameter int DECAY_STEP    = 2,
    parameter int SUSTAIN_LEVEL = 160,
    parameter int RELEASE_STEP  = 4
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_gate,
    input  logic [8:0] i_compare,
    input  logic       i_compare_valid,
    output logic [8:0] o_compare,
    output logic       o_compare_valid,
    output logic [7:0] o_level,
    output logic       o_active
);

    localparam int             CNT_W    = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);
    localparam logic [8:0]     A_STEP   = 9'(ATTACK_STEP);
    localparam logic [8:0]     D_STEP   = 9'(DECAY_STEP);
    localparam logic [8:0]     R_STEP   = 9'(RELEASE_STEP);
    localparam logic [7:0]     SUS_LVL  = 8'(SUSTAIN_LEVEL);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ATTACK,
        S_DECAY,
        S_SUSTAIN,
        S_RELEASE
    } state_t;

    state_t           state, state_nxt;
    logic [7:0]       level, level_nxt;
    logic [CNT_W-1:0] tick_cnt;
    logic             tick;
    logic             gate_q;
    logic             gate_rise, gate_fall;
    logic [8:0]       att_sum, dec_diff, rel_diff;
    logic [16:0]      prod;

    assign tick      = (tick_cnt == CNT_LAST);
    assign gate_rise = i_gate & ~gate_q;
    assign gate_fall = ~i_gate & gate_q;

    // 9-bit intermediates: bit 8 flags overflow on attack, underflow on decay/release
    assign att_sum  = {1'b0, level} + A_STEP;
    assign dec_diff = {1'b0, level} - D_STEP;
    assign rel_diff = {1'b0, level} - R_STEP;

    assign prod     = {8'd0, i_compare} * {9'd0, level};
    assign o_level  = level;
    assign o_active = (state != S_IDLE);

    // Free-running tick divider, independent of envelope state
    always_ff @(posedge i_clk) begin
        if (i_rst)     tick_cnt <= '0;
        else if (tick) tick_cnt <= '0;
        else           tick_cnt <= tick_cnt + 1'b1;
    end

    // Registered gate for edge detection; cleared so a held gate retriggers after reset
    always_ff @(posedge i_clk) begin
        if (i_rst) gate_q <= 1'b0;
        else       gate_q <= i_gate;
    end

    // Envelope state and level registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= S_IDLE;
            level <= 8'd0;
        end else begin
            state <= state_nxt;
            level <= level_nxt;
        end
    end

    // Next state/level: gate edges win over a coincident tick and freeze the level
    always_comb begin
        state_nxt = state;
        level_nxt = level;
        if (gate_rise) begin
            state_nxt = S_ATTACK;
        end else if (gate_fall) begin
            if (state inside {S_ATTACK, S_DECAY, S_SUSTAIN})
                state_nxt = S_RELEASE;
        end else if (tick) begin
            case (state)
                S_IDLE: level_nxt = 8'd0;
                S_ATTACK: begin
                    if (att_sum >= 9'd255) begin
                        level_nxt = 8'd255;
                        state_nxt = S_DECAY;
                    end else begin
                        level_nxt = att_sum[7:0];
                    end
                end
                S_DECAY: begin
                    if (dec_diff[8] || (dec_diff[7:0] <= SUS_LVL)) begin
                        level_nxt = SUS_LVL;
                        state_nxt = S_SUSTAIN;
                    end else begin
                        level_nxt = dec_diff[7:0];
                    end
                end
                S_SUSTAIN: level_nxt = level;
                S_RELEASE: begin
                    if (rel_diff[8] || (rel_diff[7:0] == 8'd0)) begin
                        level_nxt = 8'd0;
                        state_nxt = S_IDLE;
                    end else begin
                        level_nxt = rel_diff[7:0];
                    end
                end
                default: begin
                    level_nxt = 8'd0;
                    state_nxt = S_IDLE;
                end
            endcase
        end
    end

    // Scaled compare: one register stage, holds its value between valid samples
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_compare       <= 9'd0;
            o_compare_valid <= 1'b0;
        end else begin
            o_compare_valid <= i_compare_valid;
            if (i_compare_valid) o_compare <= prod[16:8];
        end
    end

endmodule

// File: tb/tb_pwm_envelope.sv
// tb_pwm_envelope: directed envelope scenarios checked against a cycle model
// of the envelope rules, plus hand-computed level/scale expectations.
module tb_pwm_envelope;

    localparam int TD = 4, AS = 64, DS = 16, SL = 128, RS = 32;
    localparam int M_IDLE = 0, M_ATT = 1, M_DEC = 2, M_SUS = 3, M_REL = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       gate = 1'b0;
    logic [8:0] cmp = 9'd0;
    logic       cv = 1'b0;
    logic [8:0] o_compare;
    logic       o_compare_valid;
    logic [7:0] o_level;
    logic       o_active;

    int tests = 0;
    int fails = 0;

    int m_cnt, m_level, m_state, m_gq, m_oc, m_ov;
    bit m_tick_last = 1'b0;
    bit chk_en = 1'b0;
    bit rnd_cmp = 1'b0;

    always #5 clk = ~clk;

    pwm_envelope #(
        .TICK_DIV(TD), .ATTACK_STEP(AS), .DECAY_STEP(DS),
        .SUSTAIN_LEVEL(SL), .RELEASE_STEP(RS)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_gate(gate),
        .i_compare(cmp), .i_compare_valid(cv),
        .o_compare(o_compare), .o_compare_valid(o_compare_valid),
        .o_level(o_level), .o_active(o_active)
    );

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Envelope model: the rules applied to integers once per clock
    always @(posedge clk) begin : model
        bit tk, rise, fall;
        if (rst) begin
            m_cnt = 0; m_level = 0; m_state = M_IDLE; m_gq = 0;
            m_oc = 0; m_ov = 0; m_tick_last = 1'b0;
        end else begin
            tk    = (m_cnt == TD - 1);
            m_cnt = (m_cnt + 1) % TD;
            rise  = gate && !m_gq;
            fall  = !gate && m_gq;
            m_ov  = cv;
            if (cv) m_oc = (int'(cmp) * m_level) / 256;
            if (rise) m_state = M_ATT;
            else if (fall) begin
                if (m_state == M_ATT || m_state == M_DEC || m_state == M_SUS) m_state = M_REL;
            end else if (tk) begin
                if (m_state == M_ATT) begin
                    m_level = (m_level + AS > 255) ? 255 : m_level + AS;
                    if (m_level == 255) m_state = M_DEC;
                end else if (m_state == M_DEC) begin
                    m_level = (m_level - DS < SL) ? SL : m_level - DS;
                    if (m_level == SL) m_state = M_SUS;
                end else if (m_state == M_REL) begin
                    m_level = (m_level - RS < 0) ? 0 : m_level - RS;
                    if (m_level == 0) m_state = M_IDLE;
                end else if (m_state == M_IDLE) begin
                    m_level = 0;
                end
            end
            m_gq = gate;
            m_tick_last = tk;
        end
    end

    // Per-cycle compare of every output against the model, away from the active edge
    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_level", o_level, m_level);
            chk("model_active", o_active, (m_state != M_IDLE));
            chk("model_ocmp", o_compare, m_oc);
            chk("model_ovld", o_compare_valid, m_ov);
        end
    end

    task automatic step();
        @(negedge clk);
        if (rnd_cmp) begin
            cmp = 9'($urandom_range(0, 511));
            cv  = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic next_tick();
        int n = 0;
        do begin
            step();
            n++;
        end while (!m_tick_last && n < TD + 2);
        if (!m_tick_last) begin
            tests++; fails++;
            $display("FAIL tick_timeout: got no tick within %0d cycles", n);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish before 200000");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_lvl;
        // Reset pulse
        @(negedge clk);
        chk_en = 1'b1;
        chk("rst_level", o_level, 0);
        chk("rst_active", o_active, 0);
        chk("rst_ocmp", o_compare, 0);
        chk("rst_ovld", o_compare_valid, 0);
        rst = 1'b0;
        gate = 1'b1;
        rnd_cmp = 1'b1;

        // Attack to 255
        for (int k = 1; k <= 4; k++) begin
            next_tick();
            exp_lvl = (k == 4) ? 255 : 64 * k;
            chk("attack_level", o_level, exp_lvl);
        end
        // Scale at level 255
        rnd_cmp = 1'b0; cmp = 9'd64; cv = 1'b1;
        step();
        chk("scale255_ocmp", o_compare, 63);
        chk("scale255_ovld", o_compare_valid, 1);
        cv = 1'b0;
        step();
        chk("scale_pulse_ovld", o_compare_valid, 0);
        chk("scale_hold_ocmp", o_compare, 63);
        rnd_cmp = 1'b1;

        // Decay to sustain, then hold
        for (int k = 1; k <= 8; k++) begin
            next_tick();
            exp_lvl = (k == 8) ? 128 : 255 - 16 * k;
            chk("decay_level", o_level, exp_lvl);
        end
        for (int k = 0; k < 10; k++) begin
            next_tick();
            chk("sustain_level", o_level, 128);
        end
        rnd_cmp = 1'b0; cmp = 9'd256; cv = 1'b1;
        step();
        chk("scale128_ocmp", o_compare, 128);
        chk("scale128_ovld", o_compare_valid, 1);
        cv = 1'b0;
        step();
        chk("scale128_ovld_drop", o_compare_valid, 0);
        rnd_cmp = 1'b1;

        // Reset in sustain with gate held
        rst = 1'b1;
        step();
        chk("midrst_level", o_level, 0);
        chk("midrst_active", o_active, 0);
        chk("midrst_ovld", o_compare_valid, 0);
        rst = 1'b0;
        next_tick();
        chk("postrst_level", o_level, 64);
        chk("postrst_active", o_active, 1);

        // Release from 128 in attack
        next_tick();
        chk("attack2_level", o_level, 128);
        gate = 1'b0;
        step();
        chk("fall_hold_level", o_level, 128);
        for (int k = 1; k <= 4; k++) begin
            next_tick();
            chk("release_level", o_level, 128 - 32 * k);
        end
        chk("idle_active", o_active, 0);

        // Retrigger during release, coincident with a tick
        gate = 1'b1;
        step();
        next_tick(); chk("re_att1", o_level, 64);
        next_tick(); chk("re_att2", o_level, 128);
        gate = 1'b0;
        step();
        next_tick(); chk("re_rel1", o_level, 96);
        next_tick(); chk("re_rel2", o_level, 64);
        for (int n = 0; n < TD + 2 && m_cnt != TD - 1; n++) step();
        gate = 1'b1;
        step();
        chk("retrig_tick_seen", m_tick_last, 1);
        chk("retrig_hold_level", o_level, 64);
        chk("retrig_active", o_active, 1);
        next_tick(); chk("retrig_att1", o_level, 128);
        next_tick(); chk("retrig_att2", o_level, 192);

        repeat (20) step();
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pwm_envelope.md
PWM_ENVELOPE -- requirements
Module: pwm_envelope

Interface
REQ-001 Parameter TICK_DIV, default 48000, SHALL set the number of i_clk cycles per envelope step (legal range 2..2^20).
REQ-002 Parameter ATTACK_STEP, default 8, SHALL set the level increment per tick in ATTACK (legal range 1..255).
REQ-003 Parameter DECAY_STEP, default 2, SHALL set the level decrement per tick in DECAY (legal range 1..255).
REQ-004 Parameter SUSTAIN_LEVEL, default 160, SHALL set the level held in SUSTAIN (legal range 0..255).
REQ-005 Parameter RELEASE_STEP, default 4, SHALL set the level decrement per tick in RELEASE (legal range 1..255).
REQ-006 i_clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-007 i_rst  input  1  SHALL be the reset: synchronous, active-high.
REQ-008 i_gate  input  1  SHALL be note-on level (1 = key held), synchronous to i_clk.
REQ-009 i_compare  input  9  SHALL be the unscaled compare sample from the waveform generator.
REQ-010 i_compare_valid  input  1  SHALL qualify i_compare.
REQ-011 o_compare  output  9  SHALL be the amplitude-scaled compare, feeding the pwm stage.
REQ-012 o_compare_valid  output  1  SHALL qualify o_compare.
REQ-013 o_level  output  8  SHALL be the current envelope level.
REQ-014 o_active  output  1  SHALL be 1 whenever the state is not IDLE.

Function
REQ-015 Tick counter SHALL count 0..TICK_DIV-1 and wrap, free-running regardless of state; the tick is asserted in the cycle where counter == TICK_DIV-1.
REQ-016 Gate edges SHALL be detected against a one-cycle-registered copy of i_gate; the registered copy is 0 after reset.
REQ-017 States SHALL be IDLE, ATTACK, DECAY, SUSTAIN, RELEASE.
REQ-018 Gate rising edge SHALL move any state to ATTACK without changing the level (retrigger starts from the current level).
REQ-019 Gate falling edge SHALL move ATTACK, DECAY or SUSTAIN to RELEASE without changing the level.
REQ-020 A gate edge SHALL take priority over a coincident tick; no level update occurs that cycle.
REQ-021 ATTACK on tick: level = min(level + ATTACK_STEP, 255); when the result equals 255 the state SHALL become DECAY in the same update.
REQ-022 DECAY on tick: level = max(level - DECAY_STEP, SUSTAIN_LEVEL); when the result equals SUSTAIN_LEVEL the state SHALL become SUSTAIN.
REQ-023 SUSTAIN SHALL hold the level until a gate edge.
REQ-024 RELEASE on tick: level = max(level - RELEASE_STEP, 0); when the result equals 0 the state SHALL become IDLE.
REQ-025 IDLE SHALL hold level 0.
REQ-026 Saturation SHALL be computed with 9-bit intermediates; the level SHALL never wrap.
REQ-027 Scaling: o_compare = (i_compare * o_level) >> 8, with a 17-bit product and bits [16:8] taken; the registered level used SHALL be the value present in the cycle i_compare_valid is sampled.
REQ-028 o_compare and o_compare_valid SHALL be registered with exactly 1 cycle of latency from i_compare/i_compare_valid.
REQ-029 o_compare SHALL hold its last value when i_compare_valid = 0.

Reset
REQ-030 While i_rst = 1 at a clock edge, the following SHALL be cleared on that edge: state = IDLE, level = 0, tick counter = 0, registered gate = 0, o_compare = 0, o_compare_valid = 0, o_active = 0.
REQ-031 Reset asserted mid-envelope SHALL abort it immediately; i_gate held high through reset release SHALL be seen as a rising edge on the first cycle after reset.

Verification (TICK_DIV=4, ATTACK_STEP=64, DECAY_STEP=16, SUSTAIN_LEVEL=128, RELEASE_STEP=32)
REQ-032 Reset: pulse i_rst for 1 cycle -> o_level=0, o_active=0, o_compare=0, o_compare_valid=0.
REQ-033 Hold the gate high -> per tick, levels 64, 128, 192, 255 (DECAY), 239 ... 143, then 128 (SUSTAIN, after 8 decay ticks); the level holds at 128 for 10 more ticks.
REQ-034 Scaling: level 128 with i_compare=256 -> o_compare=128 on the next cycle; level 255 with i_compare=64 -> 63; i_compare_valid pulsed once -> a one-cycle o_compare_valid, 1 cycle later.
REQ-035 Drop the gate at level 128 in ATTACK -> 96, 64, 32, 0, then IDLE with o_active=0.
REQ-036 Raise the gate at level 64 in RELEASE, coincident with a tick -> level stays 64 that cycle, state becomes ATTACK, next ticks 128, 192.
REQ-037 Assert i_rst in SUSTAIN with the gate high -> level 0 on the next cycle; after release, ATTACK starts from 0 (first tick gives 64).
